// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port arbiter: register map, FSM states and default widths.
package gpio_pkg;

    localparam int AW_DEF = 2;
    localparam int DW_DEF = 32;

    localparam logic [1:0] GPIO_IN1  = 2'd0;
    localparam logic [1:0] GPIO_IN2  = 2'd1;
    localparam logic [1:0] GPIO_OUT1 = 2'd2;
    localparam logic [1:0] GPIO_OUT2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/gpio_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; last_q remembers the most recently granted master.
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic last_q;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (en_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = last_q;
                gnt1_o = ~last_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    // Reset to 1 so that m0 wins the first contested cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (gnt0_o) begin
            last_q <= 1'b0;
        end else if (gnt1_o) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/gpio_port_arbiter.sv
// Shares the GPIO register port between the CPU (m0) and a secondary master (m1),
// one transaction at a time, with per-address write protection for m1.
module gpio_port_arbiter
    import gpio_pkg::*;
#(
    parameter int                      DW         = DW_DEF,
    parameter int                      AW         = AW_DEF,
    parameter logic [(2**AW)-1:0]      M1_WR_MASK = 4'b1100
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_a_i,
    input  logic [DW-1:0] m0_wd_i,
    output logic          m0_gnt_o,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rd_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_a_i,
    input  logic [DW-1:0] m1_wd_i,
    output logic          m1_gnt_o,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rd_o,
    output logic          m1_err_o,
    output logic          gpio_we_o,
    output logic [AW-1:0] gpio_a_o,
    output logic [DW-1:0] gpio_wd_o,
    input  logic [DW-1:0] gpio_rd_i
);

    state_e        state_q;
    logic          sel_q, wr_q, we_q, blk_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] wd_q, rd_q;

    logic          accept_en, accept_d;
    logic          wr_d, blk_d;
    logic [AW-1:0] a_d;
    logic [DW-1:0] wd_d;
    logic          issue, resp;

    assign accept_en = (state_q != ISSUE) && !rst_i;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (accept_en),
        .req0_i (m0_req_i),
        .req1_i (m1_req_i),
        .gnt0_o (m0_gnt_o),
        .gnt1_o (m1_gnt_o)
    );

    assign accept_d = m0_gnt_o | m1_gnt_o;
    assign wr_d     = m1_gnt_o ? m1_we_i : m0_we_i;
    assign a_d      = m1_gnt_o ? m1_a_i  : m0_a_i;
    assign wd_d     = m1_gnt_o ? m1_wd_i : m0_wd_i;
    // A blocked m1 write still runs as a normal slot, just with WE suppressed.
    assign blk_d    = m1_gnt_o && m1_we_i && !M1_WR_MASK[m1_a_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            we_q    <= 1'b0;
            blk_q   <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                ISSUE: begin
                    if (!wr_q) rd_q <= gpio_rd_i;
                    state_q <= RESP;
                end
                default: begin
                    if (accept_d) begin
                        sel_q   <= m1_gnt_o;
                        wr_q    <= wr_d;
                        we_q    <= wr_d && !blk_d;
                        blk_q   <= blk_d;
                        a_q     <= a_d;
                        wd_q    <= wd_d;
                        state_q <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign issue     = (state_q == ISSUE);
    assign resp      = (state_q == RESP);

    assign gpio_we_o = issue && we_q;
    assign gpio_a_o  = issue ? a_q  : '0;
    assign gpio_wd_o = issue ? wd_q : '0;

    assign m0_ack_o  = resp && !sel_q;
    assign m1_ack_o  = resp && sel_q;
    assign m0_rd_o   = (m0_ack_o && !wr_q) ? rd_q : '0;
    assign m1_rd_o   = (m1_ack_o && !wr_q) ? rd_q : '0;
    assign m1_err_o  = m1_ack_o && blk_q;

endmodule

// File: tb/tb_gpio_port_arbiter.sv
// Directed vector table followed by randomized traffic against a transaction-level model.
module tb_gpio_port_arbiter;

    localparam logic [3:0] MASK = 4'b1000;
    localparam int         NRAND = 400;

    typedef struct packed {
        logic        rst;
        logic        r0, w0;
        logic [1:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [1:0]  a1;
        logic [31:0] d1;
    } in_t;

    typedef struct packed {
        logic        g0, g1, gwe;
        logic [1:0]  ga;
        logic [31:0] gwd;
        logic        k0;
        logic [31:0] rd0;
        logic        k1;
        logic [31:0] rd1;
        logic        err;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct {
        bit          valid;
        int          cyc;
        bit          sel, wr, blk;
        logic [1:0]  a;
        logic [31:0] wd, rd;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_a, m1_a;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        gpio_we;
    logic [1:0]  gpio_a;
    logic [31:0] gpio_wd, gpio_rd;
    logic [31:0] gpi1, gpi2, gpo2, gpo3;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    gpio_port_arbiter #(.DW(32), .AW(2), .M1_WR_MASK(MASK)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .m0_req_i (m0_req),
        .m0_we_i  (m0_we),
        .m0_a_i   (m0_a),
        .m0_wd_i  (m0_wd),
        .m0_gnt_o (m0_gnt),
        .m0_ack_o (m0_ack),
        .m0_rd_o  (m0_rd),
        .m1_req_i (m1_req),
        .m1_we_i  (m1_we),
        .m1_a_i   (m1_a),
        .m1_wd_i  (m1_wd),
        .m1_gnt_o (m1_gnt),
        .m1_ack_o (m1_ack),
        .m1_rd_o  (m1_rd),
        .m1_err_o (m1_err),
        .gpio_we_o(gpio_we),
        .gpio_a_o (gpio_a),
        .gpio_wd_o(gpio_wd),
        .gpio_rd_i(gpio_rd)
    );

    // Minimal GPIO block: two inputs, two output registers, not touched by the arbiter reset.
    initial begin
        gpo2 = '0;
        gpo3 = '0;
    end

    always @(posedge clk) begin
        if (gpio_we && gpio_a == 2'd2) gpo2 <= gpio_wd;
        if (gpio_we && gpio_a == 2'd3) gpo3 <= gpio_wd;
    end

    always_comb begin
        case (gpio_a)
            2'd0:    gpio_rd = gpi1;
            2'd1:    gpio_rd = gpi2;
            2'd2:    gpio_rd = gpo2;
            default: gpio_rd = gpo3;
        endcase
    end

    function automatic in_t mk_in(int rs, int r0, int w0, int a0, int d0,
                                  int r1, int w1, int a1, int d1);
        in_t v;
        v.rst = 1'(rs);
        v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = 2'(a0); v.d0 = 32'(d0);
        v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = 2'(a1); v.d1 = 32'(d1);
        return v;
    endfunction

    function automatic out_t mk_out(int g0, int g1, int gwe, int ga, int gwd,
                                    int k0, int rd0, int k1, int rd1, int err);
        out_t v;
        v.g0 = 1'(g0); v.g1 = 1'(g1); v.gwe = 1'(gwe); v.ga = 2'(ga); v.gwd = 32'(gwd);
        v.k0 = 1'(k0); v.rd0 = 32'(rd0); v.k1 = 1'(k1); v.rd1 = 32'(rd1); v.err = 1'(err);
        return v;
    endfunction

    vec_t vecs[$];

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst    = i.rst;
        m0_req = i.r0; m0_we = i.w0; m0_a = i.a0; m0_wd = i.d0;
        m1_req = i.r1; m1_we = i.w1; m1_a = i.a1; m1_wd = i.d1;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act.g0 = m0_gnt; act.g1 = m1_gnt; act.gwe = gpio_we; act.ga = gpio_a; act.gwd = gpio_wd;
        act.k0 = m0_ack; act.rd0 = m0_rd; act.k1 = m1_ack; act.rd1 = m1_rd; act.err = m1_err;
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (g0 g1 gwe ga gwd k0 rd0 k1 rd1 err)", name, act, exp);
        end
    endtask

    // Reference model state: the most recent accepted transaction and the GPIO contents.
    txn_t        t;
    int          last_m;
    logic [31:0] mem[4];

    function automatic logic [31:0] read_mem(logic [1:0] a);
        if (a == 2'd0) return gpi1;
        if (a == 2'd1) return gpi2;
        return mem[a];
    endfunction

    initial begin
        in_t  zi;
        zi = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        gpi1 = 32'd10;
        gpi2 = 32'd11;
        drive(zi);
        repeat (2) @(posedge clk);

        // rst r0 w0 a0 d0 r1 w1 a1 d1  |  g0 g1 gwe ga gwd k0 rd0 k1 rd1 err
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,1,1,2,5,   0,0,0,0), mk_out(1,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,1,2,5,    0,0, 0,0,0));
        add(mk_in(0,1,0,2,0,   0,0,0,0), mk_out(1,0,0,0,0,    1,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,2,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    1,5, 0,0,0));
        add(mk_in(0,0,0,0,0,   1,0,0,0), mk_out(0,1,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 1,10,0));
        add(mk_in(0,1,0,1,0,   1,0,1,0), mk_out(1,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,1,0,1,0,   1,0,1,0), mk_out(0,0,0,1,0,    0,0, 0,0,0));
        add(mk_in(0,1,0,1,0,   1,0,1,0), mk_out(0,1,0,0,0,    1,11,0,0,0));
        add(mk_in(0,1,0,1,0,   1,0,1,0), mk_out(0,0,0,1,0,    0,0, 0,0,0));
        add(mk_in(0,1,0,1,0,   1,0,1,0), mk_out(1,0,0,0,0,    0,0, 1,11,0));
        add(mk_in(0,1,0,1,0,   1,0,1,0), mk_out(0,0,0,1,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    1,11,0,0,0));
        add(mk_in(0,0,0,0,0,   1,1,2,7), mk_out(0,1,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,2,7,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   1,1,3,9), mk_out(0,1,0,0,0,    0,0, 1,0,1));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,1,3,9,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 1,0,0));
        add(mk_in(0,1,0,2,0,   0,0,0,0), mk_out(1,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,2,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   1,0,3,0), mk_out(0,1,0,0,0,    1,5, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,3,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 1,9,0));
        add(mk_in(0,1,0,2,0,   0,0,0,0), mk_out(1,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(1,0,0,0,0,   0,0,0,0), mk_out(0,0,0,2,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,1,0,0,0,   1,0,0,0), mk_out(1,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    1,10,0,0,0));
        add(mk_in(0,1,1,3,171, 0,0,0,0), mk_out(1,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(1,0,0,0,0,   0,0,0,0), mk_out(0,0,1,3,171,  0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   1,0,3,0), mk_out(0,1,0,0,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,3,0,    0,0, 0,0,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 1,171,0));
        add(mk_in(0,0,0,0,0,   0,0,0,0), mk_out(0,0,0,0,0,    0,0, 0,0,0));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check($sformatf("vec%0d", k), vecs[k].o);
        end

        t.valid = 1'b0;
        t.cyc   = -10;
        last_m  = 1;
        mem[0]  = '0;
        mem[1]  = '0;
        mem[2]  = 32'h5;
        mem[3]  = 32'hAB;

        for (int c = 0; c < NRAND; c++) begin
            in_t  ri;
            out_t e;
            bit   issuing, acking;
            int   w;

            @(negedge clk);
            ri.rst = (c == 0) || ($urandom_range(0, 59) == 0);
            ri.r0  = ri.rst ? 1'b0 : 1'($urandom_range(0, 1));
            ri.w0  = 1'($urandom_range(0, 1));
            ri.a0  = 2'($urandom_range(0, 3));
            ri.d0  = $urandom;
            ri.r1  = ri.rst ? 1'b0 : 1'($urandom_range(0, 1));
            ri.w1  = 1'($urandom_range(0, 1));
            ri.a1  = 2'($urandom_range(0, 3));
            ri.d1  = $urandom;
            gpi1   = $urandom;
            gpi2   = $urandom;
            drive(ri);
            #1;

            issuing = t.valid && (t.cyc == c - 1);
            acking  = t.valid && (t.cyc == c - 2);
            e = '0;
            if (issuing) begin
                e.gwe = t.wr && !t.blk;
                e.ga  = t.a;
                e.gwd = t.wd;
                if (!t.wr) t.rd = read_mem(t.a);
            end
            if (acking) begin
                if (t.sel) begin
                    e.k1  = 1'b1;
                    e.rd1 = t.wr ? '0 : t.rd;
                    e.err = t.blk;
                end else begin
                    e.k0  = 1'b1;
                    e.rd0 = t.wr ? '0 : t.rd;
                end
            end
            w = -1;
            if (!issuing && !ri.rst) begin
                if (ri.r0 && ri.r1) w = 1 - last_m;
                else if (ri.r0)     w = 0;
                else if (ri.r1)     w = 1;
            end
            e.g0 = (w == 0);
            e.g1 = (w == 1);
            check($sformatf("rand%0d", c), e);

            if (issuing && t.wr && !t.blk && t.a >= 2'd2) mem[t.a] = t.wd;
            if (w >= 0) begin
                t.valid = 1'b1;
                t.cyc   = c;
                t.sel   = (w == 1);
                t.wr    = (w == 1) ? ri.w1 : ri.w0;
                t.a     = (w == 1) ? ri.a1 : ri.a0;
                t.wd    = (w == 1) ? ri.d1 : ri.d0;
                t.blk   = (w == 1) && ri.w1 && !MASK[ri.a1];
                t.rd    = '0;
                last_m  = w;
            end
            if (ri.rst) begin
                t.valid = 1'b0;
                last_m  = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gpio_port_arbiter.md
Name: gpio_port_arbiter

Overview:
- Shares the single GPIO register port (WE, A, WD, RD) between two bus masters.
  - m0 is the CPU data-memory path.
  - m1 is a secondary master, e.g. an accelerator or debug loader.
- Round-robin arbitration, one outstanding transaction at a time, registered command and read-data paths.
- Per-master write protection for m1, so it cannot disturb CPU-owned output registers.
- Sits between the address decoder / master fabric and the GPIO block.

Parameters:
- DW, 32, data width of WD/RD paths.
- AW, 2, GPIO register address width.
- M1_WR_MASK, 4'b1100, bit k=1 allows m1 to write GPIO address k. Width is 2**AW.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 command valid.
- m0_we  in  1  m0 write (1) / read (0).
- m0_a  in  AW  m0 register address.
- m0_wd  in  DW  m0 write data.
- m0_gnt  out  1  m0 command accepted this cycle (combinational).
- m0_ack  out  1  m0 transaction complete (1-cycle pulse).
- m0_rd  out  DW  m0 read data, valid while m0_ack=1.
- m1_req, m1_we, m1_a, m1_wd, m1_gnt, m1_ack, m1_rd: same as the m0 ports, for m1.
- m1_err  out  1  with m1_ack: write was blocked by M1_WR_MASK.
- gpio_we  out  1  to GPIO WE.
- gpio_a  out  AW  to GPIO A.
- gpio_wd  out  DW  to GPIO WD.
- gpio_rd  in  DW  from GPIO RD (combinational read of gpio_a).

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Acceptance:
  - Possible only in IDLE or RESP.
  - A command is accepted when reqX && gntX.
  - At most one gnt per cycle. gnt is always 0 in ISSUE.
- Round-robin:
  - Register `last` (reset 1, so m0 wins first).
  - If both request, grant the master != last.
  - If one requests, grant it.
  - `last` updates to the granted master on accept.
- On the accept edge:
  - Latch sel, we, a, wd.
  - For m1 writes with M1_WR_MASK[a]==0, latch we=0 and set blk=1.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - gpio_we = latched we; gpio_a, gpio_wd = latched values.
  - The GPIO write commits on the ISSUE→RESP edge.
  - The same edge captures gpio_rd into rd_q (reads only; rd_q holds on writes).
  - Next state is RESP.
- RESP:
  - ackX=1 for X=sel.
  - mX_rd = rd_q for reads. For writes mX_rd = 0.
  - m1_err = blk when sel=1; m1_err is always 0 for m0 transactions.
  - A new accept may occur in the same cycle → ISSUE; otherwise → IDLE.
- Outside ISSUE: gpio_we=0, gpio_a=0, gpio_wd=0.
- Timing:
  - Latency: accept in cycle N, ISSUE in N+1, ack in N+2.
  - Peak throughput: 1 transaction per 2 cycles.
- Master rule: after gnt, the master must drop req or present its next command in the following cycle. Holding req issues a second transaction.
- Outputs when not acking: mX_ack=0, mX_rd=0, m1_err=0.
- Rst asserted in any state:
  - Next cycle: IDLE, last=1, all latches and rd_q cleared, all outputs 0.
  - An in-flight transaction is dropped with no ack.
  - If Rst hits during ISSUE, the GPIO write on that edge still occurs, because the GPIO reset is separate.
- Simultaneous req from both in RESP: arbitration uses the already-updated last.

Decomposition:
- Shared package gpio_pkg:
  - GPIO address constants: GPIO_IN1=0, GPIO_IN2=1, GPIO_OUT1=2, GPIO_OUT2=3.
  - State encoding localparams: IDLE, ISSUE, RESP.
  - AW/DW defaults.
- One natural sub-module: rr_arb2, a 2-way round-robin picker with its last pointer.
- FSM, latches and the GPIO mux stay in the top.

Test Plan:
- m0 write, read-back:
  - Stimulus: Rst 1 cycle; m0 write A=2 WD=32'h5; then m0 read A=2.
  - Response: gnt in cycle 0; gpio_we=1, gpio_a=2, gpio_wd=5 in cycle 1; m0_ack in cycle 2. Read ack carries m0_rd=32'h5.
- Input read:
  - Stimulus: gpI1=10 at GPIO; m1 read A=0.
  - Response: m1_ack with m1_rd=32'd10; m1_err=0; m0_ack stays 0.
- Contention:
  - Stimulus: m0 and m1 both hold req continuously, reads A=1 with gpI2=11.
  - Response: grants alternate m0, m1, m0, m1 after reset. An ack arrives every 2 cycles, each with rd=11.
- Write protection:
  - Stimulus: M1_WR_MASK=4'b1000; m1 writes A=2 WD=7, then m1 writes A=3 WD=9.
  - Response: first write gives gpio_we=0 in ISSUE and m1_ack with m1_err=1. Second gives gpio_we=1, gpio_a=3, m1_err=0.
- Reset mid-transaction:
  - Stimulus: accept an m0 read, assert Rst in the ISSUE cycle.
  - Response: no m0_ack. All outputs 0 the next cycle; FSM is IDLE; the next dual request grants m0.
- Back-to-back from RESP:
  - Stimulus: m1 presents a new write in the cycle its previous ack is high.
  - Response: m1_gnt=1 in that RESP cycle; ISSUE follows immediately with no IDLE gap.
